// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arb_pkg
//  Purpose : Shared types and constants for the data-memory arbiter.
//            - arb_state_t : arbiter FSM states
//            - OWNER_C/D   : round-robin owner encoding (CPU / DMA)
//            - DEFAULT_BURST_MAX, WORD_BYTES
//  Revision: 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  // Arbiter FSM: IDLE arbitrates single beats, BURST holds memory for DMA.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Identity of the port that most recently used the memory.
  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Default maximum number of beats in one DMA burst.
  localparam int DEFAULT_BURST_MAX = 8;

  // Bytes per memory word; burst beats advance the address by this amount.
  localparam int WORD_BYTES = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Shares a single-port data memory between the CPU datapath
//            (port c, single beat) and a DMA/loader engine (port d, single
//            beat or incrementing burst). Two-way round-robin arbitration;
//            a granted DMA burst keeps the memory until it finishes or is
//            aborted by dropping d_req. Grants and read data are
//            combinational (zero latency); writes commit at the clock edge
//            that ends the grant cycle.
//
//  Ports   :
//    clk        in   system clock
//    reset      in   synchronous, active-low reset
//    c_req      in   CPU access request
//    c_we       in   CPU write (1) / read (0)
//    c_addr     in   CPU byte address
//    c_wdata    in   CPU write data
//    c_gnt      out  CPU access performed this cycle
//    c_rdata    out  CPU read data (mem_dout while granted, else 0)
//    d_req      in   DMA request, held high for the whole burst
//    d_we       in   DMA write/read, evaluated per beat
//    d_addr     in   DMA burst base byte address, used on the first beat
//    d_len      in   DMA burst length in beats, used on the first beat
//    d_wdata    in   DMA write data for the current beat
//    d_gnt      out  DMA beat performed this cycle
//    d_rdata    out  DMA read data (mem_dout while granted, else 0)
//    d_beat     out  0-based index of the current DMA beat
//    d_last     out  current granted beat is the final one of the burst
//    mem_addr   out  memory byte address
//    mem_din    out  memory write data
//    mem_read   out  memory read strobe
//    mem_write  out  memory write strobe
//    mem_dout   in   memory asynchronous read data
//    busy       out  arbiter is inside a DMA burst
//  Revision: 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = DEFAULT_BURST_MAX,
  parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  // CPU port
  input  logic             c_req,
  input  logic             c_we,
  input  logic [31:0]      c_addr,
  input  logic [31:0]      c_wdata,
  output logic             c_gnt,
  output logic [31:0]      c_rdata,
  // DMA port
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [LEN_W-1:0] d_len,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic [31:0]      d_rdata,
  output logic [LEN_W-1:0] d_beat,
  output logic             d_last,
  // Data memory
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_dout,
  // Status
  output logic             busy
);

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(BURST_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t       r_state;
  logic             r_last_owner;
  logic [LEN_W-1:0] r_beat;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_len;

  arb_state_t       w_state_nxt;
  logic             w_owner_nxt;
  logic [LEN_W-1:0] w_beat_nxt;
  logic [31:0]      w_base_nxt;
  logic [LEN_W-1:0] w_len_nxt;

  logic [LEN_W-1:0] w_eff_len;
  logic [31:0]      w_burst_addr;
  logic [31:0]      w_d_addr;
  logic             w_c_wins;

  // --------------------------------------------------------------------------
  // Effective burst length: zero means a single beat, oversize requests are
  // clipped to BURST_MAX.
  // --------------------------------------------------------------------------
  always_comb begin
    w_eff_len = d_len;
    if (d_len == '0) begin
      w_eff_len = c_len_one;
    end else if (d_len > c_len_max) begin
      w_eff_len = c_len_max;
    end
  end

  // Burst beat address; 32-bit addition wraps naturally past 0xFFFFFFFF.
  assign w_burst_addr = r_base + (32'(r_beat) * 32'(WORD_BYTES));

  // Round-robin tie break: the CPU wins unless it was the previous owner.
  assign w_c_wins = c_req && (!d_req || (r_last_owner == OWNER_D));

  // --------------------------------------------------------------------------
  // Next-state and grant logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_last_owner;
    w_beat_nxt  = r_beat;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    c_gnt       = 1'b0;
    d_gnt       = 1'b0;
    d_last      = 1'b0;
    d_beat      = '0;
    w_d_addr    = '0;

    // While reset is asserted nothing is granted; the registers are being
    // cleared by the sequential block, so the next-state values are moot.
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_c_wins) begin
            c_gnt       = 1'b1;
            w_owner_nxt = OWNER_C;
          end else if (d_req) begin
            d_gnt    = 1'b1;
            w_d_addr = d_addr;
            if (w_eff_len == c_len_one) begin
              d_last      = 1'b1;
              w_owner_nxt = OWNER_D;
            end else begin
              // Beat 0 is performed now; the rest run from the latched base.
              w_base_nxt  = d_addr;
              w_len_nxt   = w_eff_len;
              w_beat_nxt  = c_len_one;
              w_state_nxt = ST_BURST;
            end
          end
        end

        ST_BURST: begin
          // The CPU is stalled for the whole burst.
          d_beat      = r_beat;
          w_d_addr    = w_burst_addr;
          if (d_req) begin
            d_gnt = 1'b1;
            if (r_beat == (r_len - c_len_one)) begin
              d_last      = 1'b1;
              w_state_nxt = ST_IDLE;
              w_owner_nxt = OWNER_D;
              w_beat_nxt  = '0;
            end else begin
              w_beat_nxt = r_beat + c_len_one;
            end
          end else begin
            // Abort: no memory access this cycle, release the memory.
            w_state_nxt = ST_IDLE;
            w_owner_nxt = OWNER_D;
            w_beat_nxt  = '0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory drive and read-data return
  // --------------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_din   = c_wdata;
      mem_read  = !c_we;
      mem_write = c_we;
    end else if (d_gnt) begin
      mem_addr  = w_d_addr;
      mem_din   = d_wdata;
      mem_read  = !d_we;
      mem_write = d_we;
    end
  end

  assign c_rdata = c_gnt ? mem_dout : '0;
  assign d_rdata = d_gnt ? mem_dout : '0;
  assign busy    = (r_state == ST_BURST);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= OWNER_D;   // CPU wins the first tie after reset
      r_beat       <= '0;
      r_base       <= '0;
      r_len        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_owner_nxt;
      r_beat       <= w_beat_nxt;
      r_base       <= w_base_nxt;
      r_len        <= w_len_nxt;
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Purpose : Self-checking bench for dmem_arbiter. A table of per-cycle
//            vectors (inputs plus hand-computed expected outputs) is applied
//            one row per clock; a small word-addressed memory model answers
//            reads and commits writes so that written data can be read back.
//  Revision: 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam logic [31:0] PAT = 32'h5A00_0000;   // memory word i holds PAT|i

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_gnt;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_gnt, d_last;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_len, d_beat;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_read, mem_write, busy;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_len    (d_len),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rdata  (d_rdata),
    .d_beat   (d_beat),
    .d_last   (d_last),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // 256-word memory model, indexed by byte address bits [9:2].
  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  assign mem_dout = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= PAT | 32'(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_din;
    end
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        cr;
    logic        cw;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [3:0]  dl;
    logic [31:0] dd;
    logic        e_cg;
    logic        e_dg;
    logic        e_last;
    logic [3:0]  e_beat;
    logic        e_busy;
    logic [31:0] e_ma;
    logic        e_mr;
    logic        e_mw;
    logic        chk_rd;
    logic [31:0] e_crd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t  vecs[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    row_idx;
  string row_name;

  task automatic add(input string name, input logic rst,
                     input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [3:0] dl,
                     input logic [31:0] dd,
                     input logic e_cg, input logic e_dg, input logic e_last, input logic [3:0] e_beat,
                     input logic e_busy, input logic [31:0] e_ma, input logic e_mr, input logic e_mw,
                     input logic chk_rd, input logic [31:0] e_crd, input logic [31:0] e_drd);
    vec_t v;
    v.name = name; v.rst = rst;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dl = dl; v.dd = dd;
    v.e_cg = e_cg; v.e_dg = e_dg; v.e_last = e_last; v.e_beat = e_beat; v.e_busy = e_busy;
    v.e_ma = e_ma; v.e_mr = e_mr; v.e_mw = e_mw;
    v.chk_rd = chk_rd; v.e_crd = e_crd; v.e_drd = e_drd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row %0d (%s) %s: got %h expected %h", row_idx, row_name, what, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;

    //   name          rst cr cw  c_addr        c_wdata       dr dw  d_addr        len   d_wdata      | cg dg lst beat bsy mem_addr      mr mw chk c_rdata       d_rdata
    // Reset holds everything off, even with both ports requesting.
    add("rst_cpu",     0, 1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        4'd0, 32'h0,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    add("rst_both",    0, 1, 1, 32'h10,       32'hDEADBEEF, 1, 1, 32'h100,      4'd4, 32'h1,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    // CPU write then read-back.
    add("cpu_wr",      1, 1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h10,       0, 1, 0, 32'h0,        32'h0);
    add("cpu_rd",      1, 1, 0, 32'h10,       32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h10,       1, 0, 1, 32'hDEADBEEF, 32'h0);
    // Re-reset, then tie arbitration C, D, C, D.
    add("rst_again",   0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    add("tie_1_c",     1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        1, 0, 0, 4'd0, 0, 32'h20,       1, 0, 1, PAT|32'h08,   32'h0);
    add("tie_2_d",     1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        0, 1, 1, 4'd0, 0, 32'h30,       1, 0, 1, 32'h0,        PAT|32'h0C);
    add("tie_3_c",     1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        1, 0, 0, 4'd0, 0, 32'h20,       1, 0, 1, PAT|32'h08,   32'h0);
    add("tie_4_d",     1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        0, 1, 1, 4'd0, 0, 32'h30,       1, 0, 1, 32'h0,        PAT|32'h0C);
    // 4-beat burst, CPU stalled; beat 2 is a read to show per-beat d_we.
    add("bw_beat0",    1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h100,      4'd4, 32'h11110000, 0, 1, 0, 4'd0, 0, 32'h100,      0, 1, 0, 32'h0,        32'h0);
    add("bw_beat1",    1, 1, 0, 32'h20,       32'h0,        1, 1, 32'hDEAD0000, 4'd4, 32'h11110001, 0, 1, 0, 4'd1, 1, 32'h104,      0, 1, 0, 32'h0,        32'h0);
    add("bw_beat2",    1, 1, 0, 32'h20,       32'h0,        1, 0, 32'hDEAD0000, 4'd4, 32'h11110002, 0, 1, 0, 4'd2, 1, 32'h108,      1, 0, 1, 32'h0,        PAT|32'h42);
    add("bw_beat3",    1, 1, 0, 32'h20,       32'h0,        1, 1, 32'hDEAD0000, 4'd4, 32'h11110003, 0, 1, 1, 4'd3, 1, 32'h10C,      0, 1, 0, 32'h0,        32'h0);
    add("bw_cpu_5th",  1, 1, 0, 32'h104,      32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h104,      1, 0, 1, 32'h11110001, 32'h0);
    add("bw_rb_10c",   1, 1, 0, 32'h10C,      32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h10C,      1, 0, 1, 32'h11110003, 32'h0);
    // Abort after two granted beats.
    add("ab_beat0",    1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h200,      4'd4, 32'h22220000, 0, 1, 0, 4'd0, 0, 32'h200,      0, 1, 0, 32'h0,        32'h0);
    add("ab_beat1",    1, 1, 0, 32'h20,       32'h0,        1, 1, 32'h200,      4'd4, 32'h22220001, 0, 1, 0, 4'd1, 1, 32'h204,      0, 1, 0, 32'h0,        32'h0);
    add("ab_drop",     1, 1, 0, 32'h20,       32'h0,        0, 1, 32'h200,      4'd4, 32'h2222FFFF, 0, 0, 0, 4'd2, 1, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    add("ab_cpu",      1, 1, 0, 32'h20,       32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h20,       1, 0, 1, PAT|32'h08,   32'h0);
    add("ab_nowr",     1, 1, 0, 32'h208,      32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h208,      1, 0, 1, PAT|32'h82,   32'h0);
    // Reset in the middle of a burst.
    add("rb_beat0",    1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h300,      4'd4, 32'h33330000, 0, 1, 0, 4'd0, 0, 32'h300,      0, 1, 0, 32'h0,        32'h0);
    add("rb_reset",    0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h300,      4'd4, 32'h33330001, 0, 0, 0, 4'd0, 1, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    add("rb_idle",     1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    add("rb_nowr",     1, 1, 0, 32'h304,      32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        1, 0, 0, 4'd0, 0, 32'h304,      1, 0, 1, PAT|32'hC1,   32'h0);
    // d_len=0 is a single beat.
    add("len0_beat",   1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h40,       4'd0, 32'h0,        0, 1, 1, 4'd0, 0, 32'h40,       1, 0, 1, 32'h0,        PAT|32'h10);
    add("len0_after",  1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);
    // d_len=15 clipped to 8 beats, CPU requesting from beat 1.
    add("clip_b0",     1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h480,      4'd15, 32'h0,       0, 1, 0, 4'd0, 0, 32'h480,      1, 0, 1, 32'h0,        PAT|32'h20);
    for (int k = 1; k < 8; k++) begin
      add("clip_bn",   1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h480,      4'd15, 32'h0,       0, 1, (k == 7), 4'(k), 1, 32'h480 + 32'(4*k), 1, 0, 1, 32'h0, PAT | 32'(32'h20 + k));
    end
    // After the DMA burst the CPU wins the tie, then DMA.
    add("post_tie_c",  1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        1, 0, 0, 4'd0, 0, 32'h20,       1, 0, 1, PAT|32'h08,   32'h0);
    add("post_tie_d",  1, 1, 0, 32'h20,       32'h0,        1, 0, 32'h30,       4'd1, 32'h0,        0, 1, 1, 4'd0, 0, 32'h30,       1, 0, 1, 32'h0,        PAT|32'h0C);
    // Address wrap across 2^32.
    add("wrap_b0",     1, 0, 0, 32'h0,        32'h0,        1, 0, 32'hFFFFFFF8, 4'd3, 32'h0,        0, 1, 0, 4'd0, 0, 32'hFFFFFFF8, 1, 0, 1, 32'h0,        PAT|32'hFE);
    add("wrap_b1",     1, 0, 0, 32'h0,        32'h0,        1, 0, 32'hFFFFFFF8, 4'd3, 32'h0,        0, 1, 0, 4'd1, 1, 32'hFFFFFFFC, 1, 0, 1, 32'h0,        PAT|32'hFF);
    add("wrap_b2",     1, 0, 0, 32'h0,        32'h0,        1, 0, 32'hFFFFFFF8, 4'd3, 32'h0,        0, 1, 1, 4'd2, 1, 32'h0,        1, 0, 1, 32'h0,        PAT|32'h00);
    add("wrap_idle",   1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        4'd0, 32'h0,        0, 0, 0, 4'd0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      row_idx  = i;
      row_name = vecs[i].name;
      reset   = vecs[i].rst;
      c_req   = vecs[i].cr;  c_we = vecs[i].cw;  c_addr = vecs[i].ca;  c_wdata = vecs[i].cd;
      d_req   = vecs[i].dr;  d_we = vecs[i].dw;  d_addr = vecs[i].da;  d_len   = vecs[i].dl;
      d_wdata = vecs[i].dd;
      #1;
      chk("c_gnt",     32'(c_gnt),     32'(vecs[i].e_cg));
      chk("d_gnt",     32'(d_gnt),     32'(vecs[i].e_dg));
      chk("d_last",    32'(d_last),    32'(vecs[i].e_last));
      chk("d_beat",    32'(d_beat),    32'(vecs[i].e_beat));
      chk("busy",      32'(busy),      32'(vecs[i].e_busy));
      chk("mem_addr",  mem_addr,       vecs[i].e_ma);
      chk("mem_read",  32'(mem_read),  32'(vecs[i].e_mr));
      chk("mem_write", 32'(mem_write), 32'(vecs[i].e_mw));
      chk("both_gnt",  32'(c_gnt & d_gnt), 32'h0);
      if (vecs[i].chk_rd) begin
        chk("c_rdata", c_rdata, vecs[i].e_crd);
        chk("d_rdata", d_rdata, vecs[i].e_drd);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
